ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered EX instruction fields and the operands of M-extension instructions, computes results with a shared shift-based datapath, and stalls the front of the pipeline until the result is ready. The EX result mux selects `md_result` when `md_valid` is high; `stall_req` goes to the stall controller, which drives `stall_ctrl`.

## Interface
- `XLEN`, 64: operand/result width; only 64 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low.
- `ex_inst_type`  in  8  EX instruction class; `INST_MULDIV` selects this unit.
- `ex_inst_opcode`  in  8  one of MUL, MULH, MULHSU, MULHU, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- `ex_op1`  in  64  rs1 value (dividend / multiplicand).
- `ex_op2`  in  64  rs2 value (divisor / multiplier).
- `ex_adv`  in  1  EX/MEM register loads this cycle (EX instruction retires from EX).
- `stall_req`  out  1  combinational; holds IF/ID/EX while high.
- `md_result`  out  64  result, valid while `md_valid` is high.
- `md_valid`  out  1  registered; high in state DONE only.

## Operation
- `is_md` = (`ex_inst_type` == `INST_MULDIV`).
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE & is_md: latch operands, opcode and iteration count N; go to MUL or DIV. If the operation is a divide-by-zero or signed overflow, go straight to DONE with the special result.
  - MUL/DIV: one iteration per cycle; a 7-bit counter decrements from N; go to DONE after the last iteration.
  - DONE: hold `md_result`, `md_valid`=1; go to IDLE when `ex_adv`=1, otherwise stay. DONE never restarts on the held instruction.
- `stall_req` = (IDLE & is_md) | MUL | DIV. It is 0 in DONE and forced 0 while `rst`=0.
- N = 64 for 64-bit operations; N = 32 for the W forms, which use the low 32 bits of the operands, sign- or zero-extended per opcode.
- Multiply: radix-2 shift-add on operand magnitudes into a 128-bit accumulator; the result is negated when the operand signs differ.
  - MUL returns product[63:0]; MULH, MULHSU and MULHU return product[127:64].
  - MULHSU: op1 signed, op2 unsigned.
  - MULW returns sext(product[31:0]).
- Divide: restoring, on magnitudes; quotient sign = sign(op1)^sign(op2), remainder sign = sign(op1). W results are sext of the 32-bit result.
- Divide by zero: quotient = all ones (W: sext of 32'hFFFFFFFF); remainder = op1 (W: sext of op1[31:0]).
- Signed overflow (most negative / −1): quotient = op1 (W: sext 32'h80000000); remainder = 0.
- Reset values: state IDLE, counter 0, `md_result` 0, `md_valid` 0, `stall_req` 0.

## Timing
- The instruction enters EX at edge T; in the cycle after T, `stall_req`=1 combinationally.
- The iteration cycles follow; DONE is entered N+1 edges after T. `md_valid` and `md_result` are registered there, and `stall_req` drops in that same cycle.
- Special-case fast path: DONE at T+1, with `stall_req` high for exactly one cycle.
- Back-to-back M instructions: the second is seen in IDLE the cycle after the DONE→IDLE transition. There are no bubbles beyond that.
- Downstream stall (`ex_adv`=0 in DONE): DONE persists, the result stays stable, and no recomputation occurs.
- Reset asserted mid-iteration or in DONE: IDLE on the next edge; outputs return to reset values; the partial result is discarded.
- Operands are sampled only at IDLE→busy; changes to the `ex_*` inputs during MUL/DIV are ignored.

## Structure
- `defines.v` holds `INST_MULDIV` and the thirteen opcode constants. `RegBus` sizes the 64-bit ports.
- State encoding is local to the module.
- One natural sub-module: `ex_div_core`, the restoring divider step (remainder/quotient shift-subtract). The multiplier shift-add stays in the top level.
- Expected size: about 250 RTL lines.

## Test plan
- MUL 7 × −3 (64-bit): `stall_req` high for 65 cycles; `md_result`=0xFFFF_FFFF_FFFF_FFEB with `md_valid`=1 at T+65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → 0x1. MULH −1 × −1 → 0. MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7/2 → −3; REM −7/2 → −1; DIVUW 0xFFFF_FFFF/2 → 0x7FFF_FFFF with a 33-cycle stall.
- DIV 5/0 → all ones; REM 5/0 → 5; DIV 0x8000_0000_0000_0000/−1 → same value. REM of the same → 0. Each with a 1-cycle stall.
- Completion with `ex_adv`=0 for 4 cycles in DONE: the result is held, `stall_req`=0, no restart. `ex_adv`=1 → IDLE; the next MUL starts the following cycle.
- `rst`=0 at iteration 20 of a DIV: next cycle IDLE, `md_valid`=0, `md_result`=0, `stall_req`=0.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared constants, opcode decode and helpers for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned REG_BUS = XLEN;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned CNT_W   = 7;

  localparam logic [CNT_W-1:0] N_D = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] N_W = CNT_W'(32);

  localparam logic [XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

  localparam logic [OP_W-1:0] INST_MULDIV = 8'h05;

  localparam logic [OP_W-1:0] OP_MUL    = 8'h00;
  localparam logic [OP_W-1:0] OP_MULH   = 8'h01;
  localparam logic [OP_W-1:0] OP_MULHSU = 8'h02;
  localparam logic [OP_W-1:0] OP_MULHU  = 8'h03;
  localparam logic [OP_W-1:0] OP_MULW   = 8'h04;
  localparam logic [OP_W-1:0] OP_DIV    = 8'h05;
  localparam logic [OP_W-1:0] OP_DIVU   = 8'h06;
  localparam logic [OP_W-1:0] OP_REM    = 8'h07;
  localparam logic [OP_W-1:0] OP_REMU   = 8'h08;
  localparam logic [OP_W-1:0] OP_DIVW   = 8'h09;
  localparam logic [OP_W-1:0] OP_DIVUW  = 8'h0A;
  localparam logic [OP_W-1:0] OP_REMW   = 8'h0B;
  localparam logic [OP_W-1:0] OP_REMUW  = 8'h0C;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic is_w;
    logic a_sgn;
    logic b_sgn;
    logic hi;
  } md_dec_t;

  // Low-half products are sign-agnostic, so MUL/MULW run on unsigned operands.
  function automatic md_dec_t md_decode(input logic [OP_W-1:0] op);
    md_dec_t d;
    d = '0;
    case (op)
      OP_MULH:   begin d.a_sgn = 1'b1; d.b_sgn = 1'b1; d.hi = 1'b1; end
      OP_MULHSU: begin d.a_sgn = 1'b1; d.hi = 1'b1; end
      OP_MULHU:  d.hi = 1'b1;
      OP_MULW:   d.is_w = 1'b1;
      OP_DIV:    begin d.is_div = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
      OP_DIVU:   d.is_div = 1'b1;
      OP_REM:    begin d.is_div = 1'b1; d.is_rem = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
      OP_REMU:   begin d.is_div = 1'b1; d.is_rem = 1'b1; end
      OP_DIVW:   begin d.is_div = 1'b1; d.is_w = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
      OP_DIVUW:  begin d.is_div = 1'b1; d.is_w = 1'b1; end
      OP_REMW:   begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
      OP_REMUW:  begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; end
      default:   ;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// One restoring-division step: shift {rem, quo} left by one and subtract the divisor when it fits.
module ex_div_core
  import ex_muldiv_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem_c,
  output logic [XLEN-1:0] o_quo_c
);

  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;

  // Remainder stays below the divisor, so the difference always fits in XLEN bits.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_dvsr});
  assign w_sub   = w_shift[XLEN-1:0] - i_dvsr;

  assign o_rem_c = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign o_quo_c = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit in EX: radix-2 shift-add multiply, restoring divide,
// one iteration per cycle on a shared 128-bit accumulator; stalls the front end until done.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    ex_inst_type,
  input  logic [OP_W-1:0]    ex_inst_opcode,
  input  logic [REG_BUS-1:0] ex_op1,
  input  logic [REG_BUS-1:0] ex_op2,
  input  logic               ex_adv,
  output logic               stall_req,
  output logic [REG_BUS-1:0] md_result,
  output logic               md_valid
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div, r_is_rem, r_is_w, r_hi, r_neg, r_rneg;

  logic              w_is_md;
  md_dec_t           w_dec;
  logic [XLEN-1:0]   w_a64, w_b64, w_mag_a, w_mag_b, w_min;
  logic              w_sa, w_sb, w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_acc, w_acc_step, w_prod, w_prod_s;
  logic [XLEN-1:0]   w_div_rem, w_div_quo, w_quo_s, w_rem_s, w_div_sel, w_final;

  assign w_is_md = (ex_inst_type == INST_MULDIV);
  assign w_dec   = md_decode(ex_inst_opcode);

  // W forms see only the low word, extended per the opcode's signedness.
  always_comb begin
    w_a64 = ex_op1;
    w_b64 = ex_op2;
    if (w_dec.is_w) begin
      w_a64 = w_dec.a_sgn ? sext32(ex_op1[31:0]) : {32'b0, ex_op1[31:0]};
      w_b64 = w_dec.b_sgn ? sext32(ex_op2[31:0]) : {32'b0, ex_op2[31:0]};
    end
  end

  assign w_sa    = w_dec.a_sgn & w_a64[XLEN-1];
  assign w_sb    = w_dec.b_sgn & w_b64[XLEN-1];
  assign w_mag_a = w_sa ? -w_a64 : w_a64;
  assign w_mag_b = w_sb ? -w_b64 : w_b64;
  assign w_min   = w_dec.is_w ? MIN_W : MIN_D;

  assign w_div_zero = w_dec.is_div & (w_b64 == '0);
  assign w_div_ovf  = w_dec.is_div & w_dec.a_sgn & (w_a64 == w_min) & (w_b64 == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      if (w_dec.is_rem) w_special_res = w_dec.is_w ? sext32(ex_op1[31:0]) : ex_op1;
      else              w_special_res = '1;
    end else if (!w_dec.is_rem) begin
      w_special_res = w_a64;
    end
  end

  // Multiplier in the low half shifts out as partial products accumulate in the high half.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

  ex_div_core u_div_core (
    .i_rem   (r_acc[2*XLEN-1:XLEN]),
    .i_quo   (r_acc[XLEN-1:0]),
    .i_dvsr  (r_opnd),
    .o_rem_c (w_div_rem),
    .o_quo_c (w_div_quo)
  );

  assign w_acc_step = (r_state == S_DIV) ? {w_div_rem, w_div_quo} : w_mul_acc;

  // After 32 multiply steps the product sits 32 bits up in the accumulator.
  assign w_prod   = r_is_w ? (w_acc_step >> 32) : w_acc_step;
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo_s  = r_neg ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
  assign w_rem_s  = r_rneg ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];

  always_comb begin
    w_div_sel = r_is_rem ? w_rem_s : w_quo_s;
    if (r_is_div)  w_final = r_is_w ? sext32(w_div_sel[31:0]) : w_div_sel;
    else if (r_is_w) w_final = sext32(w_prod_s[31:0]);
    else if (r_hi)   w_final = w_prod_s[2*XLEN-1:XLEN];
    else             w_final = w_prod_s[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          stall_req = 1'b1;
          if (w_special)         w_state_nxt = S_DONE;
          else if (w_dec.is_div) w_state_nxt = S_DIV;
          else                   w_state_nxt = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        stall_req = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ex_adv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst) stall_req = 1'b0;
  end

  // Operand capture on entry, one iteration per busy cycle, result capture on the last one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_is_rem  <= 1'b0;
      r_is_w    <= 1'b0;
      r_hi      <= 1'b0;
      r_neg     <= 1'b0;
      r_rneg    <= 1'b0;
      md_result <= '0;
      md_valid  <= 1'b0;
    end else begin
      md_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_is_div <= w_dec.is_div;
            r_is_rem <= w_dec.is_rem;
            r_is_w   <= w_dec.is_w;
            r_hi     <= w_dec.hi;
            r_neg    <= w_sa ^ w_sb;
            r_rneg   <= w_sa;
            if (w_special) begin
              r_cnt     <= '0;
              md_result <= w_special_res;
            end else begin
              r_cnt <= w_dec.is_w ? N_W : N_D;
              if (w_dec.is_div) begin
                r_opnd <= w_mag_b;
                r_acc  <= {{XLEN{1'b0}}, (w_dec.is_w ? {w_mag_a[31:0], 32'b0} : w_mag_a)};
              end else begin
                r_opnd <= w_mag_a;
                r_acc  <= {{XLEN{1'b0}}, w_mag_b};
              end
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) md_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, hold/back-to-back/reset sequences,
// and randomized operations checked against a plain-arithmetic RV64M model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_inst_type, ex_inst_opcode;
  logic [63:0] ex_op1, ex_op2;
  logic        ex_adv;
  logic        stall_req;
  logic [63:0] md_result;
  logic        md_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk            (clk),
    .rst            (rst),
    .ex_inst_type   (ex_inst_type),
    .ex_inst_opcode (ex_inst_opcode),
    .ex_op1         (ex_op1),
    .ex_op2         (ex_op2),
    .ex_adv         (ex_adv),
    .stall_req      (stall_req),
    .md_result      (md_result),
    .md_valid       (md_valid)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          edges;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RV64M semantics from plain wide arithmetic, with the architectural special cases.
  function automatic logic [63:0] ref_res(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pp;
    logic [31:0]  ua, ub, p32;
    longint       sa, sb;
    int           sa32, sb32;
    logic         ovf64, ovf32;
    logic [63:0]  r;
    sa = a; sb = b; ua = a[31:0]; ub = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      OP_MUL:    begin pp = {64'b0, a} * {64'b0, b}; r = pp[63:0]; end
      OP_MULH:   begin pp = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = pp[127:64]; end
      OP_MULHSU: begin pp = {{64{a[63]}}, a} * {64'b0, b}; r = pp[127:64]; end
      OP_MULHU:  begin pp = {64'b0, a} * {64'b0, b}; r = pp[127:64]; end
      OP_MULW:   begin p32 = ua * ub; r = sx(p32); end
      OP_DIV:    if (b == 0) r = '1; else if (ovf64) r = a; else r = 64'(sa / sb);
      OP_DIVU:   if (b == 0) r = '1; else r = a / b;
      OP_REM:    if (b == 0) r = a; else if (ovf64) r = '0; else r = 64'(sa % sb);
      OP_REMU:   if (b == 0) r = a; else r = a % b;
      OP_DIVW:   if (ub == 0) r = '1; else if (ovf32) r = sx(32'h8000_0000); else r = sx(32'(sa32 / sb32));
      OP_DIVUW:  if (ub == 0) r = '1; else r = sx(ua / ub);
      OP_REMW:   if (ub == 0) r = sx(ua); else if (ovf32) r = '0; else r = sx(32'(sa32 % sb32));
      OP_REMUW:  if (ub == 0) r = sx(ua); else r = sx(ua % ub);
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_edges(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic w, dv, sdiv, zero, ovf;
    w    = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    dv   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    sdiv = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sdiv && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (dv && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0:       r = '0;
      1:       r = '1;
      2:       r = 64'h8000_0000_0000_0000;
      3:       r = 64'($urandom_range(0, 20));
      4:       r = {$urandom, $urandom};
      default: r = {$urandom, 32'h8000_0000};
    endcase
    return r;
  endfunction

  // Entered and left just after a rising edge; the instruction enters EX at the preceding edge.
  task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_ed, input int hold, input string tag);
    int  edges, stalls;
    logic done;
    ex_inst_type = INST_MULDIV; ex_inst_opcode = op; ex_op1 = a; ex_op2 = b; ex_adv = 1'b0;
    edges = 0; stalls = 0; done = 1'b0;
    while (!done && edges < 100) begin
      @(negedge clk);
      if (stall_req) stalls++;
      @(posedge clk); #1;
      edges++;
      if (exp_ed > 1 && edges == 3) begin
        ex_op1 = {$urandom, $urandom};
        ex_op2 = {$urandom, $urandom};
        ex_inst_opcode = 8'($urandom_range(0, 12));
      end
      done = md_valid;
    end
    check($sformatf("%s latency", tag), 64'(edges), 64'(exp_ed));
    check($sformatf("%s stall cycles", tag), 64'(stalls), 64'(exp_ed));
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check($sformatf("%s result(h%0d)", tag, h), md_result, exp);
      check($sformatf("%s valid(h%0d)", tag, h), 64'(md_valid), 64'd1);
      check($sformatf("%s stall in done(h%0d)", tag, h), 64'(stall_req), 64'd0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    ex_adv = 1'b1;
    @(posedge clk); #1;
    ex_adv = 1'b0; ex_inst_type = 8'h00;
    check($sformatf("%s valid after adv", tag), 64'(md_valid), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ex_inst_type = INST_MULDIV; ex_inst_opcode = OP_MUL;
    ex_op1 = 64'd3; ex_op2 = 64'd4; ex_adv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 64'(md_valid), 64'd0);
    check("reset result", md_result, 64'd0);
    check("reset stall forced low", 64'(stall_req), 64'd0);
    ex_inst_type = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle no-md stall", 64'(stall_req), 64'd0);

    vecs.push_back('{OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 65});
    vecs.push_back('{OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65});
    vecs.push_back('{OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{OP_DIVUW,  64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33});
    vecs.push_back('{OP_DIVU,   64'd100, 64'd7, 64'd14, 65});
    vecs.push_back('{OP_REMU,   64'd100, 64'd7, 64'd2, 65});
    vecs.push_back('{OP_DIVW,   64'h1234_5678_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{OP_REMW,   64'h1234_5678_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{OP_DIV,    64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{OP_REM,    64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{OP_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1});
    vecs.push_back('{OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{OP_REMUW,  64'hAAAA_0000_8000_0007, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0007, 1});

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].edges, 0, $sformatf("vec%0d", i));

    // Downstream stall in DONE for 4 cycles, then an immediate back-to-back MUL.
    run_op(OP_MUL, 64'd3, 64'd5, 64'd15, 65, 4, "hold");
    run_op(OP_MUL, 64'd6, 64'd7, 64'd42, 65, 0, "b2b");

    // Reset at iteration 20 of a divide discards the partial result.
    ex_inst_type = INST_MULDIV; ex_inst_opcode = OP_DIV; ex_op1 = 64'd1000; ex_op2 = 64'd7;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check("mid-div stall", 64'(stall_req), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid-reset valid", 64'(md_valid), 64'd0);
    check("mid-reset result", md_result, 64'd0);
    check("mid-reset stall", 64'(stall_req), 64'd0);
    ex_inst_type = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-reset valid", 64'(md_valid), 64'd0);
    check("post-reset stall", 64'(stall_req), 64'd0);
    run_op(OP_DIVU, 64'd1000, 64'd7, 64'd142, 65, 1, "post-reset");

    for (int i = 0; i < 150; i++) begin
      logic [7:0]  op;
      logic [63:0] a, b;
      op = 8'($urandom_range(0, 12));
      a  = pick();
      b  = pick();
      run_op(op, a, b, ref_res(op, a, b), exp_edges(op, a, b), $urandom_range(0, 2),
             $sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
